// File: rtl/fft_frame_feeder.sv
// Captures a raw sample stream into two ping-pong frame banks and streams whole FFT_LEN-point
// frames to the FFT core over AXI-Stream, after sending one config word following reset.
module fft_frame_feeder #(
  parameter int               FFT_LEN  = 1024,
  parameter int               SAMPLE_W = 14,
  parameter int               CFG_W    = 16,
  parameter logic [CFG_W-1:0] CFG_WORD = 16'h0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                s_axis_config_tvalid,
  output logic [CFG_W-1:0]    s_axis_config_tdata,
  input  logic                s_axis_config_tready,
  output logic                s_axis_data_tvalid,
  output logic [31:0]         s_axis_data_tdata,
  output logic                s_axis_data_tlast,
  input  logic                s_axis_data_tready,
  output logic [15:0]         frame_cnt,
  output logic                overflow,
  output logic                busy
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {CFG, IDLE, STREAM} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] mem [0:2*FFT_LEN-1];
  logic [1:0]          occupied;
  logic                wr_bank;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_bank;
  logic [IDX_W-1:0]    rd_idx;
  logic                out_bank;
  logic [SAMPLE_W-1:0] out_sample;

  logic xfer;
  logic frame_done;
  logic can_load;
  logic load;
  logic wr_en;

  // A bank stays occupied from its last write until its tlast beat leaves the output register.
  assign xfer       = s_axis_data_tvalid & s_axis_data_tready;
  assign frame_done = xfer & s_axis_data_tlast;
  assign can_load   = ~s_axis_data_tvalid | s_axis_data_tready;
  assign load       = (state != CFG) & occupied[rd_bank] & can_load;
  // The bank being freed by this cycle's tlast may already take the writer's sample.
  assign wr_en      = in_valid & (~occupied[wr_bank] | (frame_done & (out_bank == wr_bank)));

  assign s_axis_config_tdata = CFG_WORD;
  assign s_axis_data_tdata   = {16'h0000, 16'($signed(out_sample))};
  assign busy                = (state == STREAM) | (|occupied);

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= CFG;
      s_axis_config_tvalid <= 1'b0;
      occupied             <= 2'b00;
      wr_bank              <= 1'b0;
      wr_idx               <= '0;
      rd_bank              <= 1'b0;
      rd_idx               <= '0;
      out_bank             <= 1'b0;
      out_sample           <= '0;
      s_axis_data_tvalid   <= 1'b0;
      s_axis_data_tlast    <= 1'b0;
      frame_cnt            <= '0;
      overflow             <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end else if (in_valid) begin
        overflow <= 1'b1;
      end

      if (frame_done) begin
        occupied[out_bank] <= 1'b0;
        frame_cnt          <= frame_cnt + 16'd1;
      end
      if (wr_en && (wr_idx == LAST_IDX)) occupied[wr_bank] <= 1'b1;

      // Prefetch straight from the banks so frames follow each other without bubbles.
      if (load) begin
        s_axis_data_tvalid <= 1'b1;
        out_sample         <= mem[{rd_bank, rd_idx}];
        s_axis_data_tlast  <= (rd_idx == LAST_IDX);
        out_bank           <= rd_bank;
        if (rd_idx == LAST_IDX) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end else if (xfer) begin
        s_axis_data_tvalid <= 1'b0;
        s_axis_data_tlast  <= 1'b0;
      end

      case (state)
        CFG: begin
          if (s_axis_config_tvalid && s_axis_config_tready) begin
            s_axis_config_tvalid <= 1'b0;
            state                <= IDLE;
          end else begin
            s_axis_config_tvalid <= 1'b1;
          end
        end
        IDLE, STREAM: begin
          if (load) begin
            state <= ((rd_idx == LAST_IDX) && !occupied[~rd_bank]) ? IDLE : STREAM;
          end
        end
        default: state <= CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: a frame-level model predicts accepted samples and
// the delivered beat stream, while scenario tasks check config, latency, bubbles and overflow.
module tb_fft_frame_feeder;

  localparam int N  = 1024;
  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic          s_axis_config_tvalid;
  logic [15:0]   s_axis_config_tdata;
  logic          s_axis_config_tready = 1'b0;
  logic          s_axis_data_tvalid;
  logic [31:0]   s_axis_data_tdata;
  logic          s_axis_data_tlast;
  logic          s_axis_data_tready = 1'b0;
  logic [15:0]   frame_cnt;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  fft_frame_feeder #(
    .FFT_LEN(N), .SAMPLE_W(SW), .CFG_W(16), .CFG_WORD(16'h0001)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .s_axis_config_tvalid(s_axis_config_tvalid), .s_axis_config_tdata(s_axis_config_tdata),
    .s_axis_config_tready(s_axis_config_tready),
    .s_axis_data_tvalid(s_axis_data_tvalid), .s_axis_data_tdata(s_axis_data_tdata),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .frame_cnt(frame_cnt), .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: samples of whole frames awaiting delivery, the frame being collected,
  // and the number of complete frames the two banks currently hold.
  int          exp_q[$];
  int          part_q[$];
  int          held = 0;
  int          beat_idx = 0;
  int          rx_beats = 0;
  logic [31:0] first_rx = '0;
  logic [31:0] last_rx = '0;
  bit          stall_prev = 0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;
  bit          done_now;
  int          v;
  logic [31:0] exp_word;
  logic        exp_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      held       = 0;
      beat_idx   = 0;
      stall_prev = 0;
    end else begin
      done_now = s_axis_data_tvalid && s_axis_data_tready && s_axis_data_tlast;
      if (stall_prev) begin
        checks++;
        if (s_axis_data_tvalid !== 1'b1 || s_axis_data_tdata !== stall_data ||
            s_axis_data_tlast !== stall_last) begin
          failures++;
          $display("[TB] FAIL hold_stable got=%b/%h/%b exp=1/%h/%b", s_axis_data_tvalid,
                   s_axis_data_tdata, s_axis_data_tlast, stall_data, stall_last);
        end
      end
      stall_prev = s_axis_data_tvalid && !s_axis_data_tready;
      stall_data = s_axis_data_tdata;
      stall_last = s_axis_data_tlast;

      if (s_axis_data_tvalid && s_axis_data_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_beat got=%h exp=none", s_axis_data_tdata);
        end else begin
          v        = exp_q.pop_front();
          exp_word = {16'h0000, 16'(v)};
          exp_last = (beat_idx == N - 1);
          if (s_axis_data_tdata !== exp_word || s_axis_data_tlast !== exp_last) begin
            failures++;
            $display("[TB] FAIL beat_data idx=%0d got=%h/%b exp=%h/%b", beat_idx,
                     s_axis_data_tdata, s_axis_data_tlast, exp_word, exp_last);
          end
        end
        if (rx_beats == 0) first_rx = s_axis_data_tdata;
        last_rx  = s_axis_data_tdata;
        rx_beats = rx_beats + 1;
        beat_idx = (beat_idx + 1) % N;
      end

      if (in_valid && (held < 2 || done_now)) begin
        part_q.push_back(int'($signed(in_data)));
        if (part_q.size() == N) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          held++;
        end
      end
      if (done_now) held--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget, input int ready_pct,
                             output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (frame_cnt == 16'(target)) begin
        ok = 1;
        break;
      end
      s_axis_data_tready = ($urandom_range(0, 99) < ready_pct);
      tick();
    end
  endtask

  task automatic test_reset();
    int          beats = 0;
    logic [15:0] cfg_seen = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    s_axis_config_tready = 1'b0;
    s_axis_data_tready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({s_axis_config_tvalid, s_axis_data_tvalid, s_axis_data_tlast, overflow, busy} !== 5'b0 ||
        frame_cnt !== 16'd0 || s_axis_data_tdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b%b%b%b%b cnt=%h data=%h exp=00000 cnt=0 data=0",
               s_axis_config_tvalid, s_axis_data_tvalid, s_axis_data_tlast, overflow, busy,
               frame_cnt, s_axis_data_tdata);
    end
    checks++;
    if (s_axis_config_tdata !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL reset_cfg_word got=%h exp=0001", s_axis_config_tdata);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_axis_config_tvalid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfg_pending got=%b exp=1", s_axis_config_tvalid);
    end
    s_axis_config_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_axis_config_tvalid && s_axis_config_tready) begin
        beats++;
        cfg_seen = s_axis_config_tdata;
      end
      tick();
    end
    checks++;
    if (beats != 1) begin
      failures++;
      $display("[TB] FAIL cfg_beat_count got=%0d exp=1", beats);
    end
    checks++;
    if (cfg_seen !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL cfg_beat_word got=%h exp=0001", cfg_seen);
    end
  endtask

  task automatic test_ramp();
    int n = 0;
    bit ok;
    rx_beats = 0;
    s_axis_data_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = SW'(i);
      tick();
    end
    in_valid = 1'b0;
    while (!s_axis_data_tvalid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n > 2) begin
      failures++;
      $display("[TB] FAIL first_beat_latency got=%0d exp<=2", n);
    end
    wait_frames(1, 3000, 100, ok);
    checks++;
    if (!ok || frame_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL ramp_frame_cnt got=%0d exp=1", frame_cnt);
    end
    checks++;
    if (rx_beats != N || last_rx !== 32'h000003FF) begin
      failures++;
      $display("[TB] FAIL ramp_beats got=%0d/%h exp=%0d/000003ff", rx_beats, last_rx, N);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rx_beats = 0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 14'h2000;
      s_axis_data_tready = $urandom_range(0, 1) != 0;
      tick();
    end
    in_valid = 1'b0;
    wait_frames(2, 5000, 50, ok);
    checks++;
    if (!ok || frame_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL bp_frame_cnt got=%0d exp=2", frame_cnt);
    end
    checks++;
    if (rx_beats != N || last_rx !== 32'h0000E000) begin
      failures++;
      $display("[TB] FAIL bp_beats got=%0d/%h exp=%0d/0000e000", rx_beats, last_rx, N);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_overflow got=%b exp=0", overflow);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    bit ok;
    rx_beats = 0;
    while (sent < 2 * N) begin
      in_valid = ($urandom_range(0, 99) < 40);
      in_data  = SW'($urandom);
      if (in_valid) sent++;
      s_axis_data_tready = ($urandom_range(0, 99) < 75);
      tick();
    end
    in_valid = 1'b0;
    wait_frames(4, 6000, 75, ok);
    checks++;
    if (!ok || frame_cnt !== 16'd4) begin
      failures++;
      $display("[TB] FAIL rand_frame_cnt got=%0d exp=4", frame_cnt);
    end
    checks++;
    if (rx_beats != 2 * N || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rand_beats got=%0d/%b exp=%0d/0", rx_beats, overflow, 2 * N);
    end
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    bit started = 0;
    bit done = 0;
    rx_beats = 0;
    s_axis_data_tready = 1'b1;
    for (int c = 0; c < 4 * N + 2000; c++) begin
      in_valid = (c < 4 * N);
      in_data  = SW'($urandom);
      tick();
      if (frame_cnt == 16'd8) begin
        done = 1;
        break;
      end
      if (started && !s_axis_data_tvalid) bubbles++;
      if (s_axis_data_tvalid) started = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL b2b_frame_cnt got=%0d exp=8", frame_cnt);
    end
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("[TB] FAIL b2b_bubbles got=%0d exp=0", bubbles);
    end
    checks++;
    if (overflow !== 1'b0 || rx_beats != 4 * N) begin
      failures++;
      $display("[TB] FAIL b2b_stream got=%b/%0d exp=0/%0d", overflow, rx_beats, 4 * N);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    rx_beats = 0;
    s_axis_data_tready = 1'b0;
    for (int c = 0; c < 2100; c++) begin
      in_valid = 1'b1;
      in_data  = SW'($urandom);
      tick();
    end
    checks++;
    if (overflow !== 1'b1 || s_axis_data_tvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_flag got=%b/%b/%b exp=1/1/1", overflow, s_axis_data_tvalid, busy);
    end
    s_axis_data_tready = 1'b1;
    for (int c = 0; c < 2100; c++) begin
      in_valid = 1'b1;
      in_data  = SW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_frames(11, 4000, 100, ok);
    checks++;
    if (!ok || frame_cnt !== 16'd11) begin
      failures++;
      $display("[TB] FAIL ovf_frame_cnt got=%0d exp=11", frame_cnt);
    end
    checks++;
    if (rx_beats != 3 * N || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_beats got=%0d/%b exp=%0d/1", rx_beats, overflow, 3 * N);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int cfg_beats = 0;
    bit hit = 0;
    s_axis_data_tready = 1'b1;
    s_axis_config_tready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'b1;
      in_data  = SW'($urandom);
      tick();
      if (beat_idx == 500) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL mid_reach_beat500 got=%0d exp=500", beat_idx);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    checks++;
    if ({s_axis_data_tvalid, s_axis_config_tvalid, overflow, busy} !== 4'b0 ||
        frame_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs got=%b%b%b%b cnt=%0d exp=0000 cnt=0",
               s_axis_data_tvalid, s_axis_config_tvalid, overflow, busy, frame_cnt);
    end
    rst = 1'b0;
    rx_beats = 0;
    for (int i = 0; i < N; i++) begin
      if (s_axis_config_tvalid && s_axis_config_tready) cfg_beats++;
      in_valid = 1'b1;
      in_data  = SW'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_frames(1, 3000, 100, ok);
    checks++;
    if (cfg_beats != 1) begin
      failures++;
      $display("[TB] FAIL mid_cfg_resent got=%0d exp=1", cfg_beats);
    end
    checks++;
    if (!ok || frame_cnt !== 16'd1 || rx_beats != N) begin
      failures++;
      $display("[TB] FAIL mid_frame got=%0d/%0d exp=1/%0d", frame_cnt, rx_beats, N);
    end
    checks++;
    if (first_rx !== 32'h0 || exp_q.size() != 0 || part_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL mid_first_sample got=%h/%0d/%0d exp=0/0/0", first_rx, exp_q.size(),
               part_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
